// File: rtl/zeroriscy_prefetch_queue_if.sv
// Core-side and memory-side handshake signals of the instruction prefetch queue.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface zeroriscy_prefetch_queue_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i;
  logic        instr_rvalid_i;
  logic        busy_o;

  modport slave (
    input  req_i, branch_i, addr_i, ready_i, instr_gnt_i, instr_rdata_i, instr_rvalid_i,
    output valid_o, rdata_o, addr_o, instr_req_o, instr_addr_o, busy_o
  );

  modport master (
    output req_i, branch_i, addr_i, ready_i, instr_gnt_i, instr_rdata_i, instr_rvalid_i,
    input  valid_o, rdata_o, addr_o, instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/zeroriscy_prefetch_queue.sv
// Instruction prefetch queue: issues word fetches with credit-based flow control,
// tracks in-flight requests, discards stale responses after a branch.
module zeroriscy_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  zeroriscy_prefetch_queue_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE, WAIT_GNT} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_addr;
  logic [OW-1:0] r_out_cnt;
  logic [OW-1:0] r_disc_cnt;
  logic [31:0]   r_aq [MAX_OUT];
  logic [QW-1:0] r_aq_rd;
  logic [QW-1:0] r_aq_wr;
  logic [31:0]   r_fifo_addr [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [31:0]   w_target;
  logic [31:0]   w_addr;
  logic          w_rvalid;
  logic [SW-1:0] w_committed;
  logic          w_out_room;
  logic          w_can_issue;
  logic          w_req;
  logic          w_gnt;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_unused;

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [QW-1:0] aq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUT - 1)) ? '0 : p + QW'(1);
  endfunction

  assign w_target = {bus.addr_i[31:2], 2'b00};
  assign w_unused = ^bus.addr_i[1:0];

  // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign w_rvalid = bus.instr_rvalid_i && (r_out_cnt != '0);

  // Entries already stored plus responses still to be stored must fit in the FIFO.
  assign w_committed = SW'(r_count) + SW'(r_out_cnt - r_disc_cnt);
  assign w_out_room  = r_out_cnt < OW'(MAX_OUT);
  assign w_can_issue = w_out_room && (w_committed < SW'(DEPTH));

  // A branch flushes the FIFO, so it only needs a free address-queue slot to issue.
  assign w_req = rst_n && ((r_state == WAIT_GNT) ||
                 (bus.req_i && (w_can_issue || (bus.branch_i && w_out_room))));
  assign w_addr = bus.branch_i ? w_target : r_fetch_addr;
  assign w_gnt  = w_req && bus.instr_gnt_i;

  assign w_push  = w_rvalid && !bus.branch_i && (r_disc_cnt == '0);
  assign w_valid = r_count != '0;
  assign w_pop   = w_valid && bus.ready_i && !bus.branch_i;

  assign bus.instr_req_o  = w_req;
  assign bus.instr_addr_o = w_addr;
  assign bus.valid_o      = w_valid;
  assign bus.rdata_o      = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.addr_o       = w_valid ? r_fifo_addr[r_rd_ptr] : '0;
  assign bus.busy_o       = (r_out_cnt != '0) || w_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_fetch_addr <= '0;
      r_out_cnt    <= '0;
      r_disc_cnt   <= '0;
      r_aq_rd      <= '0;
      r_aq_wr      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        IDLE:     if (w_req && !bus.instr_gnt_i) r_state <= WAIT_GNT;
        WAIT_GNT: if (bus.instr_gnt_i) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase

      if (w_gnt)
        r_fetch_addr <= w_addr + 32'd4;
      else if (bus.branch_i)
        r_fetch_addr <= w_target;

      if (w_gnt && !w_rvalid)
        r_out_cnt <= r_out_cnt + OW'(1);
      else if (!w_gnt && w_rvalid)
        r_out_cnt <= r_out_cnt - OW'(1);

      // Everything in flight before the branch is stale; a grant this cycle is not.
      if (bus.branch_i)
        r_disc_cnt <= w_rvalid ? r_out_cnt - OW'(1) : r_out_cnt;
      else if (w_rvalid && (r_disc_cnt != '0))
        r_disc_cnt <= r_disc_cnt - OW'(1);

      if (w_gnt)    r_aq_wr <= aq_inc(r_aq_wr);
      if (w_rvalid) r_aq_rd <= aq_inc(r_aq_rd);

      if (bus.branch_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= fifo_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= fifo_inc(r_rd_ptr);
        if (w_push && !w_pop)
          r_count <= r_count + CW'(1);
        else if (!w_push && w_pop)
          r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt)
      r_aq[r_aq_wr] <= w_addr;
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_aq[r_aq_rd];
      r_fifo_data[r_wr_ptr] <= bus.instr_rdata_i;
    end
  end

endmodule

// File: tb/tb_zeroriscy_prefetch_queue.sv
// Directed bench for zeroriscy_prefetch_queue: a one-cycle-latency memory model
// answers grants in order; expected values are hand-computed constants.
module tb_zeroriscy_prefetch_queue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  zeroriscy_prefetch_queue_if bus ();

  zeroriscy_prefetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic        rsp_en;
  logic [31:0] mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] out_a[$];
  logic [31:0] out_d[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record grants and core pops, then present the next memory response.
  task automatic tick();
    #1;
    if (bus.instr_req_o && bus.instr_gnt_i) begin
      mem_q.push_back(bus.instr_addr_o);
      req_log.push_back(bus.instr_addr_o);
    end
    if (bus.valid_o && bus.ready_i) begin
      out_a.push_back(bus.addr_o);
      out_d.push_back(bus.rdata_o);
    end
    @(posedge clk);
    #1;
    bus.branch_i = 1'b0;
    if (rsp_en && mem_q.size() > 0) begin
      bus.instr_rvalid_i = 1'b1;
      bus.instr_rdata_i  = mem_word(mem_q.pop_front());
    end else begin
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = '0;
    end
  endtask

  task automatic drain(input int n);
    bus.req_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    req_log.delete();
    out_a.delete();
    out_d.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    rsp_en             = 1'b1;
    bus.req_i          = 1'b1;
    bus.branch_i       = 1'b1;
    bus.addr_i         = 32'h0000_1234;
    bus.ready_i        = 1'b1;
    bus.instr_gnt_i    = 1'b1;
    bus.instr_rdata_i  = '0;
    bus.instr_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.valid_o, 0);
    check("rst_req", bus.instr_req_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_rdata", bus.rdata_o, 0);
    check("rst_addr", bus.addr_o, 0);

    bus.branch_i = 1'b0;
    bus.req_i    = 1'b0;
    rst_n        = 1'b1;
    #1;
    check("post_rst_no_req", bus.instr_req_o, 0);
    check("post_rst_fetch_addr", bus.instr_addr_o, 0);

    // Streaming from 0x100 with one-cycle responses
    clear_logs();
    bus.req_i    = 1'b1;
    bus.branch_i = 1'b1;
    bus.addr_i   = 32'h0000_0103;
    #1;
    check("t2_req", bus.instr_req_o, 1);
    check("t2_addr_align", bus.instr_addr_o, 32'h0000_0100);
    tick();
    #1;
    check("t2_no_bypass", bus.valid_o, 0);
    check("t2_next_addr", bus.instr_addr_o, 32'h0000_0104);
    tick();
    #1;
    check("t2_first_valid", bus.valid_o, 1);
    check("t2_first_addr", bus.addr_o, 32'h0000_0100);
    check("t2_first_data", bus.rdata_o, 32'hDEAD_0100);
    repeat (4) tick();
    drain(6);
    check("t2_n_req", 32'(req_log.size()), 6);
    check("t2_n_out", 32'(out_a.size()), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_req%0d", i), req_log[i], 32'h0000_0100 + 32'(4 * i));
      check($sformatf("t2_out%0d", i), out_a[i], 32'h0000_0100 + 32'(4 * i));
      check($sformatf("t2_dat%0d", i), out_d[i], 32'hDEAD_0100 + 32'(4 * i));
    end
    check("t2_idle_busy", bus.busy_o, 0);

    // Core stalls: FIFO fills to DEPTH and fetching stops
    clear_logs();
    bus.ready_i  = 1'b0;
    bus.req_i    = 1'b1;
    bus.branch_i = 1'b1;
    bus.addr_i   = 32'h0000_0300;
    tick();
    repeat (4) tick();
    #1;
    check("t3_full_no_req", bus.instr_req_o, 0);
    check("t3_full_busy", bus.busy_o, 0);
    check("t3_head_valid", bus.valid_o, 1);
    check("t3_head_addr", bus.addr_o, 32'h0000_0300);
    check("t3_head_data", bus.rdata_o, 32'hDEAD_0300);
    check("t3_n_req_full", 32'(req_log.size()), 4);
    tick();
    tick();
    #1;
    check("t3_still_stalled", bus.instr_req_o, 0);
    bus.ready_i = 1'b1;
    repeat (3) tick();
    drain(8);
    check("t3_n_req", 32'(req_log.size()), 6);
    check("t3_n_out", 32'(out_a.size()), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_out%0d", i), out_a[i], 32'h0000_0300 + 32'(4 * i));
    check("t3_last_data", out_d[5], 32'hDEAD_0314);

    // Two in flight, then branch to 0x200: stale responses dropped
    clear_logs();
    rsp_en    = 1'b0;
    bus.req_i = 1'b1;
    tick();
    tick();
    #1;
    check("t4_out_limit", bus.instr_req_o, 0);
    check("t4_busy", bus.busy_o, 1);
    bus.branch_i = 1'b1;
    bus.addr_i   = 32'h0000_0200;
    rsp_en       = 1'b1;
    tick();
    #1;
    check("t4_stale0", bus.valid_o, 0);
    tick();
    #1;
    check("t4_stale1", bus.valid_o, 0);
    tick();
    #1;
    check("t4_stale2", bus.valid_o, 0);
    tick();
    #1;
    check("t4_first_valid", bus.valid_o, 1);
    check("t4_first_addr", bus.addr_o, 32'h0000_0200);
    check("t4_first_data", bus.rdata_o, 32'hDEAD_0200);
    drain(6);
    check("t4_n_req", 32'(req_log.size()), 4);
    check("t4_req0", req_log[0], 32'h0000_0318);
    check("t4_n_out", 32'(out_a.size()), 2);
    check("t4_out0", out_a[0], 32'h0000_0200);
    check("t4_out1", out_a[1], 32'h0000_0204);

    // Grant withheld for three cycles, branch during the wait
    clear_logs();
    bus.instr_gnt_i = 1'b0;
    bus.req_i       = 1'b1;
    #1;
    check("t5_req_a", bus.instr_req_o, 1);
    check("t5_addr_a", bus.instr_addr_o, 32'h0000_0208);
    tick();
    bus.req_i    = 1'b0;
    bus.branch_i = 1'b1;
    bus.addr_i   = 32'h0000_040A;
    #1;
    check("t5_req_b", bus.instr_req_o, 1);
    check("t5_addr_b", bus.instr_addr_o, 32'h0000_0408);
    tick();
    #1;
    check("t5_req_c", bus.instr_req_o, 1);
    check("t5_addr_c", bus.instr_addr_o, 32'h0000_0408);
    tick();
    bus.instr_gnt_i = 1'b1;
    #1;
    check("t5_req_d", bus.instr_req_o, 1);
    check("t5_addr_d", bus.instr_addr_o, 32'h0000_0408);
    tick();
    #1;
    check("t5_req_after_gnt", bus.instr_req_o, 0);
    drain(4);
    check("t5_n_req", 32'(req_log.size()), 1);
    check("t5_n_out", 32'(out_a.size()), 1);
    check("t5_out0", out_a[0], 32'h0000_0408);

    // Address wrap at the top of memory
    clear_logs();
    bus.req_i    = 1'b1;
    bus.branch_i = 1'b1;
    bus.addr_i   = 32'hFFFF_FFFC;
    #1;
    check("t6_addr_top", bus.instr_addr_o, 32'hFFFF_FFFC);
    tick();
    #1;
    check("t6_wrap", bus.instr_addr_o, 32'h0000_0000);
    tick();
    drain(5);
    check("t6_n_out", 32'(out_a.size()), 2);
    check("t6_out0", out_a[0], 32'hFFFF_FFFC);
    check("t6_dat0", out_d[0], 32'h2152_FFFC);
    check("t6_out1", out_a[1], 32'h0000_0000);
    check("t6_dat1", out_d[1], 32'hDEAD_0000);

    // Reset with one entry queued and two requests in flight
    clear_logs();
    bus.ready_i  = 1'b0;
    bus.req_i    = 1'b1;
    bus.branch_i = 1'b1;
    bus.addr_i   = 32'h0000_0500;
    tick();
    rsp_en = 1'b0;
    tick();
    tick();
    #1;
    check("t7_pre_valid", bus.valid_o, 1);
    check("t7_pre_addr", bus.addr_o, 32'h0000_0500);
    check("t7_pre_busy", bus.busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", bus.valid_o, 0);
    check("t7_rst_req", bus.instr_req_o, 0);
    check("t7_rst_busy", bus.busy_o, 0);
    check("t7_rst_rdata", bus.rdata_o, 0);
    check("t7_rst_addr", bus.addr_o, 0);
    tick();
    tick();
    rst_n       = 1'b1;
    bus.req_i   = 1'b0;
    bus.ready_i = 1'b1;
    rsp_en      = 1'b1;
    #1;
    check("t7_no_req_after_rst", bus.instr_req_o, 0);
    repeat (4) tick();
    #1;
    check("t7_late_valid", bus.valid_o, 0);
    check("t7_late_busy", bus.busy_o, 0);
    check("t7_late_n_out", 32'(out_a.size()), 0);
    check("t7_fetch_reset", bus.instr_addr_o, 0);
    bus.req_i    = 1'b1;
    bus.branch_i = 1'b1;
    bus.addr_i   = 32'h0000_0600;
    #1;
    check("t7_branch_addr", bus.instr_addr_o, 32'h0000_0600);
    tick();
    drain(5);
    check("t7_n_out", 32'(out_a.size()), 1);
    check("t7_out0", out_a[0], 32'h0000_0600);
    check("t7_dat0", out_d[0], 32'hDEAD_0600);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
